// File: rtl/mulres_pkg.sv
// Shared types and constants for the multiplier result stage.
package mulres_pkg;

  typedef enum logic [1:0] {
    MUL_LO = 2'd0,
    MULH   = 2'd1,
    MULHSU = 2'd2,
    MULHU  = 2'd3
  } mul_op_e;

  localparam int unsigned MULRES_DEPTH = 2;

endpackage

// File: rtl/mulres_fix.sv
// Combinational half select and signed-operand correction of a raw unsigned product.
module mulres_fix
  import mulres_pkg::*;
#(
  parameter int unsigned N = 16
) (
  input  mul_op_e        op,
  input  logic [N-1:0]   rs1,
  input  logic [N-1:0]   rs2,
  input  logic [2*N-1:0] product,
  output logic [N-1:0]   result
);

  logic [N-1:0] hi;
  logic [N-1:0] lo;
  logic [N-1:0] corr_rs1;
  logic [N-1:0] corr_rs2;

  assign hi = product[2*N-1:N];
  assign lo = product[N-1:0];

  // A negative operand read as unsigned adds (other operand << N); remove it from hi.
  assign corr_rs1 = rs1[N-1] ? rs2 : '0;
  assign corr_rs2 = rs2[N-1] ? rs1 : '0;

  always_comb begin
    result = lo;
    case (op)
      MUL_LO:  result = lo;
      MULH:    result = hi - corr_rs1 - corr_rs2;
      MULHSU:  result = hi - corr_rs1;
      MULHU:   result = hi;
      default: result = lo;
    endcase
  end

endmodule

// File: rtl/mul_result_stage.sv
// Registered multiplier result stage with a 2-entry in-order skid FIFO.
// Optional macro MULRES_RD0_DROP_EN: accepted entries with rd==0 are discarded.
module mul_result_stage
  import mulres_pkg::*;
#(
  parameter int unsigned N    = 16,
  parameter int unsigned RD_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_op,
  input  logic [N-1:0]    in_rs1_reg,
  input  logic [N-1:0]    in_rs2_reg,
  input  logic [2*N-1:0]  in_mul_rd,
  input  logic [RD_W-1:0] in_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N-1:0]    out_data,
  output logic [RD_W-1:0] out_rd
);

  localparam int unsigned PTR_W = $clog2(MULRES_DEPTH);

  typedef enum logic [1:0] {
    CNT_EMPTY = 2'd0,
    CNT_ONE   = 2'd1,
    CNT_FULL  = 2'd2
  } cnt_e;

  cnt_e             cnt_q;
  cnt_e             cnt_d;
  logic             rdy_q;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [N-1:0]     data_mem [MULRES_DEPTH];
  logic [RD_W-1:0]  rd_mem   [MULRES_DEPTH];
  logic [N-1:0]     fix_result;
  logic             push;
  logic             enq;
  logic             pop;

  mulres_fix #(.N(N)) u_fix (
    .op      (mul_op_e'(in_op)),
    .rs1     (in_rs1_reg),
    .rs2     (in_rs2_reg),
    .product (in_mul_rd),
    .result  (fix_result)
  );

  assign in_ready  = rdy_q;
  assign out_valid = (cnt_q != CNT_EMPTY);
  assign out_data  = data_mem[rd_ptr];
  assign out_rd    = rd_mem[rd_ptr];

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

`ifdef MULRES_RD0_DROP_EN
  assign enq = push && (in_rd != '0);
`else
  assign enq = push;
`endif

  always_comb begin
    cnt_d = cnt_q;
    if (enq && !pop) begin
      case (cnt_q)
        CNT_EMPTY: cnt_d = CNT_ONE;
        CNT_ONE:   cnt_d = CNT_FULL;
        default:   cnt_d = cnt_q;
      endcase
    end else if (pop && !enq) begin
      case (cnt_q)
        CNT_FULL: cnt_d = CNT_ONE;
        CNT_ONE:  cnt_d = CNT_EMPTY;
        default:  cnt_d = cnt_q;
      endcase
    end
  end

  // in_ready is a register tracking the next count so out_ready never reaches it combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= CNT_EMPTY;
      rdy_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      rdy_q <= (cnt_d != CNT_FULL);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int unsigned i = 0; i < MULRES_DEPTH; i++) begin
        data_mem[i] <= '0;
        rd_mem[i]   <= '0;
      end
    end else begin
      if (enq) begin
        data_mem[wr_ptr] <= fix_result;
        rd_mem[wr_ptr]   <= in_rd;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mul_result_stage.sv
// Self-checking bench for mul_result_stage: vector table, scoreboard monitor, corner sequences.
module tb_mul_result_stage;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] rs1;
    logic [15:0] rs2;
    logic [31:0] prod;
    logic [4:0]  rd;
    logic [15:0] exp;
  } vec_t;

  typedef struct packed {
    logic [15:0] data;
    logic [4:0]  rd;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_op = '0;
  logic [15:0] in_rs1_reg = '0;
  logic [15:0] in_rs2_reg = '0;
  logic [31:0] in_mul_rd = '0;
  logic [4:0]  in_rd = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic [4:0]  out_rd;

  logic [15:0] cur_exp = '0;
  int          errors = 0;
  int          checks = 0;
  sb_t         sb_q[$];
  vec_t        tbl[7];
  vec_t        va, vb, vc, vz;

  mul_result_stage #(.N(16), .RD_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_rs1_reg (in_rs1_reg),
    .in_rs2_reg (in_rs2_reg),
    .in_mul_rd  (in_mul_rd),
    .in_rd      (in_rd),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_rd     (out_rd)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    in_valid   = 1'b1;
    in_op      = v.op;
    in_rs1_reg = v.rs1;
    in_rs2_reg = v.rs2;
    in_mul_rd  = v.prod;
    in_rd      = v.rd;
    cur_exp    = v.exp;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_op    = 2'($urandom_range(0, 3));
    in_rd    = 5'($urandom_range(0, 31));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: pops are compared before the same-cycle push is recorded.
  always @(negedge clk) begin
    sb_t e;
    if (!rst) begin
      if (out_valid && out_ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got data=0x%0h rd=%0d with nothing expected", out_data, out_rd);
        end else begin
          e = sb_q.pop_front();
          if (out_data !== e.data || out_rd !== e.rd) begin
            errors++;
            $display("FAIL sb_order: got data=0x%0h rd=%0d expected data=0x%0h rd=%0d",
                     out_data, out_rd, e.data, e.rd);
          end
        end
      end
      if (in_valid && in_ready) begin
`ifdef MULRES_RD0_DROP_EN
        if (in_rd != 5'd0) sb_q.push_back({cur_exp, in_rd});
`else
        sb_q.push_back({cur_exp, in_rd});
`endif
      end
    end
  end

  initial begin
    tbl[0] = '{2'd0, 16'hFFFF, 16'h0002, 32'h0001FFFE, 5'd1,  16'hFFFE};
    tbl[1] = '{2'd3, 16'hFFFF, 16'h0002, 32'h0001FFFE, 5'd2,  16'h0001};
    tbl[2] = '{2'd1, 16'hFFFF, 16'h0002, 32'h0001FFFE, 5'd3,  16'hFFFF};
    tbl[3] = '{2'd2, 16'hFFFF, 16'h0002, 32'h0001FFFE, 5'd4,  16'hFFFF};
    tbl[4] = '{2'd1, 16'h8000, 16'h8000, 32'h40000000, 5'd5,  16'h4000};
    tbl[5] = '{2'd3, 16'h8000, 16'h8000, 32'h40000000, 5'd6,  16'h4000};
    tbl[6] = '{2'd2, 16'h8000, 16'h8000, 32'h40000000, 5'd31, 16'hC000};
    va = '{2'd0, 16'h0005, 16'h0007, 32'h00000023, 5'd1, 16'h0023};
    vb = '{2'd3, 16'h1234, 16'h0100, 32'h00123400, 5'd2, 16'h0012};
    vc = '{2'd2, 16'h0003, 16'hFFFF, 32'h0002FFFD, 5'd3, 16'h0002};
    vz = '{2'd0, 16'h0003, 16'h0004, 32'h0000000C, 5'd0, 16'h000C};

    // Reset state
    step();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_rd", 32'(out_rd), 32'd0);
    rst = 1'b0;
    step();
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Back-to-back table, each result visible one cycle after its push
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      drive(tbl[i]);
      step();
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("vec%0d_data", i), 32'(out_data), 32'(tbl[i].exp));
      chk($sformatf("vec%0d_rd", i), 32'(out_rd), 32'(tbl[i].rd));
    end
    idle();
    step();
    chk("drain_valid", 32'(out_valid), 32'd0);

    // Backpressure: three pushes attempted while out_ready=0
    out_ready = 1'b0;
    drive(va);
    step();
    chk("bp_ready_after1", 32'(in_ready), 32'd1);
    chk("bp_head_a", 32'(out_data), 32'h0023);
    drive(vb);
    step();
    chk("bp_ready_after2", 32'(in_ready), 32'd0);
    drive(vc);
    step();
    chk("bp_ready_full", 32'(in_ready), 32'd0);
    chk("bp_hold_data", 32'(out_data), 32'h0023);
    chk("bp_hold_rd", 32'(out_rd), 32'd1);
    step();
    chk("bp_hold_data2", 32'(out_data), 32'h0023);
    // FULL with simultaneous pop: C is still offered but cannot enter this cycle
    out_ready = 1'b1;
    step();
    chk("fullpop_ready", 32'(in_ready), 32'd1);
    chk("fullpop_valid", 32'(out_valid), 32'd1);
    chk("fullpop_head_b", 32'(out_data), 32'h0012);
    chk("fullpop_rd_b", 32'(out_rd), 32'd2);
    step();
    chk("c_head_data", 32'(out_data), 32'h0002);
    chk("c_head_rd", 32'(out_rd), 32'd3);
    idle();
    step();
    chk("bp_drained", 32'(out_valid), 32'd0);
    chk("bp_sb_empty", 32'(sb_q.size()), 32'd0);

    // Reset while FULL
    out_ready = 1'b0;
    drive(va);
    step();
    drive(vb);
    step();
    idle();
    chk("pre_rst_full", 32'(in_ready), 32'd0);
    rst = 1'b1;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_ready", 32'(in_ready), 32'd0);
    sb_q.delete();
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    step();
    chk("rel_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("no_stale%0d", i), 32'(out_valid), 32'd0);
      step();
    end

    // rd == 0 entry
    drive(vz);
    #1;
    chk("rd0_ready", 32'(in_ready), 32'd1);
    step();
    idle();
`ifdef MULRES_RD0_DROP_EN
    chk("rd0_dropped", 32'(out_valid), 32'd0);
`else
    chk("rd0_valid", 32'(out_valid), 32'd1);
    chk("rd0_data", 32'(out_data), 32'h000C);
    chk("rd0_rd", 32'(out_rd), 32'd0);
`endif
    step();
    chk("final_empty", 32'(out_valid), 32'd0);
    chk("final_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
